// File: rtl/cesar_sched_pkg.sv
// Shared types and widths for the cesarcipher job scheduler.
package cesar_sched_pkg;

  localparam int unsigned PALAVRA_W = 64;
  localparam int unsigned N_W       = 32;
  localparam int unsigned JOB_ID_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } state_e;

  typedef struct packed {
    logic [PALAVRA_W-1:0] addr;
    logic [N_W-1:0]       n;
    logic [JOB_ID_W-1:0]  id;
  } job_t;

endpackage

// File: rtl/cesar_job_fifo.sv
// Job queue: DEPTH-entry FIFO of job_t with registered count and status flags.
module cesar_job_fifo
  import cesar_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  job_t                   push_data,
  input  logic                   pop,
  output job_t                   pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  job_t             mem_q [DEPTH];
  job_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             ready_q, ready_d;
  logic             do_push, do_pop;

  // Guard against overflow/underflow regardless of caller discipline.
  always_comb begin
    do_push  = push && (count_q < CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    empty_d = (count_d == '0);
    ready_d = (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = empty_q;
  assign ready    = ready_q;

endmodule

// File: rtl/cesar_job_scheduler.sv
// Queues cipher jobs and runs them one at a time on the cesarcipher HLS core,
// reporting each completion with its tag and accept-to-done latency.
module cesar_job_scheduler
  import cesar_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = JOB_ID_W,
  parameter int unsigned CYC_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [63:0]            job_addr,
  input  logic [31:0]            job_n,
  input  logic [ID_W-1:0]        job_id,
  output logic                   cc_start,
  input  logic                   cc_busy,
  output logic [63:0]            cc_palavra,
  output logic [31:0]            cc_n,
  input  logic                   cc_done,
  output logic                   cc_stall,
  output logic                   cmp_valid,
  input  logic                   cmp_ready,
  output logic [ID_W-1:0]        cmp_id,
  output logic [CYC_W-1:0]       cmp_cycles,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   idle,
  output logic                   err_spurious
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  job_t             arg_q, arg_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             cc_start_q, cc_start_d;
  logic             cc_stall_q, cc_stall_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic [ID_W-1:0]  cmp_id_q, cmp_id_d;
  logic [CYC_W-1:0] cmp_cycles_q, cmp_cycles_d;
  logic             idle_q, idle_d;
  logic             err_q, err_d;

  logic             fifo_push, fifo_pop, fifo_empty, fifo_ready;
  logic [CNT_W-1:0] fifo_count, count_nxt;
  job_t             fifo_in, fifo_head;

  assign fifo_push = job_valid && fifo_ready;
  assign fifo_in   = '{addr: job_addr, n: job_n, id: JOB_ID_W'(job_id)};

  cesar_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .ready     (fifo_ready)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CYC_W'(1);

  always_comb begin
    state_d      = state_q;
    arg_d        = arg_q;
    cnt_d        = cnt_q;
    cmp_valid_d  = cmp_valid_q;
    cmp_id_d     = cmp_id_q;
    cmp_cycles_d = cmp_cycles_q;
    fifo_pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          arg_d    = fifo_head;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!cc_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (cc_done) begin
          cmp_id_d     = ID_W'(arg_q.id);
          cmp_cycles_d = cnt_inc;
          cmp_valid_d  = 1'b1;
          state_d      = S_REPORT;
        end
      end
      S_REPORT: begin
        if (cmp_ready) begin
          cmp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered copies of the next-state decode.
    count_nxt  = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    cc_start_d = (state_d == S_LAUNCH);
    cc_stall_d = (state_d != S_WAIT);
    idle_d     = (count_nxt == '0) && (state_d == S_IDLE);
    err_d      = err_q || (cc_done && (state_q != S_WAIT));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      arg_q        <= '0;
      cnt_q        <= '0;
      cc_start_q   <= 1'b0;
      cc_stall_q   <= 1'b1;
      cmp_valid_q  <= 1'b0;
      cmp_id_q     <= '0;
      cmp_cycles_q <= '0;
      idle_q       <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      arg_q        <= arg_d;
      cnt_q        <= cnt_d;
      cc_start_q   <= cc_start_d;
      cc_stall_q   <= cc_stall_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_id_q     <= cmp_id_d;
      cmp_cycles_q <= cmp_cycles_d;
      idle_q       <= idle_d;
      err_q        <= err_d;
    end
  end

  assign job_ready    = fifo_ready;
  assign cc_start     = cc_start_q;
  assign cc_palavra   = arg_q.addr;
  assign cc_n         = arg_q.n;
  assign cc_stall     = cc_stall_q;
  assign cmp_valid    = cmp_valid_q;
  assign cmp_id       = cmp_id_q;
  assign cmp_cycles   = cmp_cycles_q;
  assign q_count      = fifo_count;
  assign idle         = idle_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_cesar_job_scheduler.sv
// Directed bench for cesar_job_scheduler: job table plus hand-written corner sequences.
module tb_cesar_job_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [63:0] job_addr = '0;
  logic [31:0] job_n = '0;
  logic [3:0]  job_id = '0;
  logic        cc_start;
  logic        cc_busy = 1'b0;
  logic [63:0] cc_palavra;
  logic [31:0] cc_n;
  logic        cc_done = 1'b0;
  logic        cc_stall;
  logic        cmp_valid;
  logic        cmp_ready = 1'b0;
  logic [3:0]  cmp_id;
  logic [31:0] cmp_cycles;
  logic [2:0]  q_count;
  logic        idle;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;

  cesar_job_scheduler #(.DEPTH(4), .ID_W(4), .CYC_W(32)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_addr(job_addr), .job_n(job_n), .job_id(job_id),
    .cc_start(cc_start), .cc_busy(cc_busy), .cc_palavra(cc_palavra), .cc_n(cc_n),
    .cc_done(cc_done), .cc_stall(cc_stall),
    .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_id(cmp_id), .cmp_cycles(cmp_cycles),
    .q_count(q_count), .idle(idle), .err_spurious(err_spurious)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] n;
    logic [3:0]  id;
    int          busy;
    int          delay;
    int          hold;
    int          exp_starts;
    logic [31:0] exp_cycles;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; a job offered while job_ready was high is withdrawn after.
  task automatic tick();
    logic acc;
    acc = job_valid && job_ready;
    @(posedge clock);
    #1;
    if (acc) job_valid = 1'b0;
  endtask

  task automatic offer(input logic [63:0] a, input logic [31:0] n, input logic [3:0] id);
    job_addr  = a;
    job_n     = n;
    job_id    = id;
    job_valid = 1'b1;
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    while (!cc_start && k < 30) begin
      tick();
      k++;
    end
    check({name, "_start_seen"}, 64'(cc_start), 64'd1);
  endtask

  // Completion with cc_done sampled on the delay-th edge after the accept edge.
  task automatic finish_call(input int delay, input logic [3:0] exp_id, input logic [31:0] exp_cyc, input string name);
    for (int i = 1; i < delay; i++) tick();
    cc_done = 1'b1;
    tick();
    cc_done = 1'b0;
    check({name, "_cmp_valid"}, 64'(cmp_valid), 64'd1);
    check({name, "_cmp_id"}, 64'(cmp_id), 64'(exp_id));
    check({name, "_cmp_cycles"}, 64'(cmp_cycles), 64'(exp_cyc));
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int starts;
    offer(v.addr, v.n, v.id);
    cc_busy = (v.busy > 0);
    tick();
    check({name, "_qcount_after_push"}, 64'(q_count), 64'd1);
    check({name, "_idle_after_push"}, 64'(idle), 64'd0);
    tick();
    starts = 0;
    for (int s = 0; s <= v.busy; s++) begin
      if (cc_start) starts++;
      check({name, "_palavra"}, cc_palavra, v.addr);
      check({name, "_n"}, 64'(cc_n), 64'(v.n));
      if (s == v.busy) cc_busy = 1'b0;
      tick();
    end
    check({name, "_start_cycles"}, 64'(starts), 64'(v.exp_starts));
    check({name, "_start_low_in_wait"}, 64'(cc_start), 64'd0);
    check({name, "_stall_low_in_wait"}, 64'(cc_stall), 64'd0);
    finish_call(v.delay, v.id, v.exp_cycles, name);
    for (int h = 0; h < v.hold; h++) begin
      tick();
      check({name, "_hold_valid"}, 64'(cmp_valid), 64'd1);
      check({name, "_hold_cycles"}, 64'(cmp_cycles), 64'(v.exp_cycles));
      check({name, "_hold_nostart"}, 64'(cc_start), 64'd0);
      check({name, "_hold_stall"}, 64'(cc_stall), 64'd1);
    end
    cmp_ready = 1'b1;
    tick();
    cmp_ready = 1'b0;
    check({name, "_valid_cleared"}, 64'(cmp_valid), 64'd0);
    check({name, "_idle_after"}, 64'(idle), 64'd1);
  endtask

  initial begin
    vecs[0] = '{addr: 64'h1000, n: 32'd3, id: 4'd5, busy: 0, delay: 10, hold: 0, exp_starts: 1, exp_cycles: 32'd10};
    vecs[1] = '{addr: 64'hDEAD_BEEF_0000_0040, n: 32'd25, id: 4'd9, busy: 4, delay: 1, hold: 0, exp_starts: 5, exp_cycles: 32'd1};
    vecs[2] = '{addr: 64'h8, n: 32'd0, id: 4'd0, busy: 1, delay: 2, hold: 6, exp_starts: 2, exp_cycles: 32'd2};
    vecs[3] = '{addr: 64'hFFFF_FFFF_FFFF_FFFF, n: 32'hFFFF_FFFF, id: 4'd15, busy: 0, delay: 37, hold: 0, exp_starts: 1, exp_cycles: 32'd37};

    tick();
    tick();
    reset = 1'b0;
    check("rst_job_ready", 64'(job_ready), 64'd1);
    check("rst_cc_start", 64'(cc_start), 64'd0);
    check("rst_cc_stall", 64'(cc_stall), 64'd1);
    check("rst_cmp_valid", 64'(cmp_valid), 64'd0);
    check("rst_cmp_id", 64'(cmp_id), 64'd0);
    check("rst_cmp_cycles", 64'(cmp_cycles), 64'd0);
    check("rst_q_count", 64'(q_count), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_err", 64'(err_spurious), 64'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Six jobs against a stalled cipher: one in flight, four queued, one held.
    cc_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(64'h2000 + 64'(i), 32'(i), 4'(i));
      tick();
    end
    check("full_qcount", 64'(q_count), 64'd4);
    check("full_ready", 64'(job_ready), 64'd0);
    check("full_start", 64'(cc_start), 64'd1);
    check("full_palavra", cc_palavra, 64'h2000);
    offer(64'h2005, 32'd5, 4'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_held_qcount", 64'(q_count), 64'd4);
    end
    cc_busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_start($sformatf("order%0d", k));
      check($sformatf("order%0d_palavra", k), cc_palavra, 64'h2000 + 64'(k));
      tick();
      finish_call(3, 4'(k), 32'd3, $sformatf("order%0d", k));
      cmp_ready = 1'b1;
      tick();
      cmp_ready = 1'b0;
    end
    check("order_idle", 64'(idle), 64'd1);

    // Spurious return while idle.
    cc_done = 1'b1;
    tick();
    cc_done = 1'b0;
    check("spur_err", 64'(err_spurious), 64'd1);
    check("spur_idle", 64'(idle), 64'd1);
    check("spur_nostart", 64'(cc_start), 64'd0);
    tick();
    tick();
    check("spur_sticky", 64'(err_spurious), 64'd1);

    // Reset in S_WAIT with two jobs queued.
    offer(64'h3000, 32'd7, 4'd3);
    tick();
    wait_start("rstw");
    tick();
    offer(64'h3001, 32'd8, 4'd4);
    tick();
    offer(64'h3002, 32'd9, 4'd6);
    tick();
    check("rstw_qcount", 64'(q_count), 64'd2);
    check("rstw_stall_low", 64'(cc_stall), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstw_q_count", 64'(q_count), 64'd0);
    check("rstw_start", 64'(cc_start), 64'd0);
    check("rstw_cmp_valid", 64'(cmp_valid), 64'd0);
    check("rstw_idle", 64'(idle), 64'd1);
    check("rstw_err_cleared", 64'(err_spurious), 64'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("rstw_no_cmp", 64'(cmp_valid), 64'd0);
      check("rstw_no_start", 64'(cc_start), 64'd0);
    end
    run_vec(vecs[0], "recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
